video_ts_render: RTL and testbench

Tile/sprite line renderer that sits directly downstream of the tile/sprite processing unit. It accepts one render task per handshake: a bitmap page, line, column, X position, width, flip and palette. It fetches the 4bpp graphics words from DRAM and writes the non-transparent pixels, with palette applied, into the TS line buffer. It then signals ready for the next task.

---
 rtl/video_ts_render_if.sv | 30 +++
 rtl/video_ts_render.sv | 134 +++++++++++++
 tb/tb_video_ts_render.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_ts_render_if.sv
// video_ts_render_if: task, DRAM and line-buffer signals of the tile/sprite line renderer.
interface video_ts_render_if;
  logic        start;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;
  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic        lb_we;
  logic [8:0]  lb_addr;
  logic [7:0]  lb_data;
  modport master (
    output start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    output dram_next, dram_rdata,
    input  tsr_rdy, dram_addr, dram_req, lb_we, lb_addr, lb_data
  );
  modport slave (
    input  start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    input  dram_next, dram_rdata,
    output tsr_rdy, dram_addr, dram_req, lb_we, lb_addr, lb_data
  );
endinterface

// File: rtl/video_ts_render.sv
// video_ts_render: fetches 4bpp graphics words and writes palette-tagged opaque pixels to the TS line buffer.
module video_ts_render #(
  parameter int VIS_W = 360
) (
  input logic              clk,
  input logic              rst_n,
  video_ts_render_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;
  localparam logic [9:0] VIS = 10'(VIS_W);
  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [8:0]  line_q, line_d;
  logic [5:0]  col_q, col_d;
  logic        xf_q, xf_d;
  logic [3:0]  pal_q, pal_d;
  logic [3:0]  nm1_q, nm1_d;
  logic [3:0]  w_q, w_d;
  logic [8:0]  px_q, px_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  pix_q, pix_d;
  logic        rdy_q, rdy_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [20:0] daddr_q, daddr_d;
  logic [8:0]  laddr_q, laddr_d;
  logic [7:0]  ldata_q, ldata_d;
  logic        draw;
  logic        last;
  logic [1:0]  sel;
  logic [3:0]  nib;
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    line_d  = line_q;
    col_d   = col_q;
    xf_d    = xf_q;
    pal_d   = pal_q;
    nm1_d   = nm1_q;
    w_d     = w_q;
    px_d    = px_q;
    data_d  = data_q;
    pix_d   = pix_q;
    draw    = 1'b0;
    last    = xf_q ? (w_q == 4'd0) : (w_q == nm1_q);
    case (state_q)
      IDLE: if (bus.tsr_go) begin
        page_d  = bus.tsr_page;
        line_d  = bus.tsr_line;
        col_d   = bus.tsr_addr;
        xf_d    = bus.tsr_xf;
        pal_d   = bus.tsr_pal;
        nm1_d   = {bus.tsr_xs, 1'b1};
        w_d     = bus.tsr_xf ? {bus.tsr_xs, 1'b1} : 4'd0;
        px_d    = bus.tsr_x;
        state_d = FETCH;
      end
      FETCH: if (bus.dram_next) begin
        data_d  = bus.dram_rdata;
        pix_d   = 2'd0;
        px_d    = px_q + 9'd1;
        draw    = 1'b1;
        state_d = DRAW;
      end
      DRAW: if (pix_q == 2'd3) begin
        state_d = last ? IDLE : FETCH;
        w_d     = xf_q ? w_q - 4'd1 : w_q + 4'd1;
      end else begin
        pix_d = pix_q + 2'd1;
        px_d  = px_q + 9'd1;
        draw  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (bus.start) begin
      state_d = IDLE;
      draw    = 1'b0;
    end
    // flipped order is the normal nibble order reversed
    sel     = xf_q ? ~pix_d : pix_d;
    nib     = sel == 2'd0 ? data_d[7:4] : sel == 2'd1 ? data_d[3:0] : sel == 2'd2 ? data_d[15:12] : data_d[11:8];
    rdy_d   = state_d == IDLE;
    req_d   = state_d == FETCH;
    daddr_d = req_d ? {page_d, 13'b0} + 21'({line_d, 7'b0}) + 21'({col_d, 1'b0}) + 21'(w_d) : '0;
    we_d    = draw && nib != 4'd0 && {1'b0, px_q} < VIS;
    laddr_d = draw ? px_q : '0;
    ldata_d = draw ? {pal_q, nib} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      page_q  <= '0;
      line_q  <= '0;
      col_q   <= '0;
      xf_q    <= 1'b0;
      pal_q   <= '0;
      nm1_q   <= '0;
      w_q     <= '0;
      px_q    <= '0;
      data_q  <= '0;
      pix_q   <= '0;
      rdy_q   <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      daddr_q <= '0;
      laddr_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      line_q  <= line_d;
      col_q   <= col_d;
      xf_q    <= xf_d;
      pal_q   <= pal_d;
      nm1_q   <= nm1_d;
      w_q     <= w_d;
      px_q    <= px_d;
      data_q  <= data_d;
      pix_q   <= pix_d;
      rdy_q   <= rdy_d;
      req_q   <= req_d;
      we_q    <= we_d;
      daddr_q <= daddr_d;
      laddr_q <= laddr_d;
      ldata_q <= ldata_d;
    end
  end
  assign bus.tsr_rdy   = rdy_q;
  assign bus.dram_req  = req_q;
  assign bus.dram_addr = daddr_q;
  assign bus.lb_we     = we_q;
  assign bus.lb_addr   = laddr_q;
  assign bus.lb_data   = ldata_q;
endmodule

// File: tb/tb_video_ts_render.sv
// tb_video_ts_render: scoreboard bench with a pixel-list reference model and a randomised DRAM responder.
module tb_video_ts_render;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  video_ts_render_if bus();
  video_ts_render dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int nvec = 0;
  int nfail = 0;
  logic [20:0] exp_a[$];
  logic [16:0] exp_w[$];
  logic        use_fix = 1'b0;
  logic [15:0] fix[2];
  int          wcnt = 0;
  int          wlo = 0;
  int          whi = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask
  // DRAM contents: fixed words for directed cases, otherwise a hash with frequent zero nibbles
  function automatic logic [15:0] word(input logic [20:0] a);
    logic [31:0] h;
    if (use_fix) return fix[a[0]];
    h = {11'b0, a} * 32'h9E3779B1;
    h = h ^ (h >> 13);
    return h[31:16] & {{4{h[3]}}, {4{h[2]}}, {4{h[1]}}, {4{h[0]}}};
  endfunction
  // Reference: build the task's whole pixel row in memory order, reverse it for X flip, place at x mod 512
  task automatic push_model(input int page, input int line, input int col, input int x, input int xs, input int xf, input int pal);
    int n;
    int base;
    logic [3:0] pix[$];
    logic [15:0] d;
    n = 2 * (xs + 1);
    base = page * 8192 + line * 128 + col * 2;
    for (int k = 0; k < n; k++) exp_a.push_back(21'((base + (xf != 0 ? n - 1 - k : k)) % 2097152));
    for (int w = 0; w < n; w++) begin
      d = word(21'((base + w) % 2097152));
      pix.push_back(d[7:4]);
      pix.push_back(d[3:0]);
      pix.push_back(d[15:12]);
      pix.push_back(d[11:8]);
    end
    for (int i = 0; i < 4 * n; i++) begin
      int xx;
      logic [3:0] p;
      xx = (x + i) % 512;
      p = pix[xf != 0 ? 4 * n - 1 - i : i];
      if (p != 4'd0 && xx < 360) exp_w.push_back({9'(xx), 4'(pal), p});
    end
  endtask
  task automatic set_wait(input int lo, input int hi);
    wlo = lo;
    whi = hi;
    wcnt = $urandom_range(hi, lo);
  endtask
  task automatic go(input int page, input int line, input int col, input int x, input int xs, input int xf, input int pal);
    int t;
    t = 0;
    while (!bus.tsr_rdy && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    push_model(page, line, col, x, xs, xf, pal);
    bus.tsr_page = 8'(page);
    bus.tsr_line = 9'(line);
    bus.tsr_addr = 6'(col);
    bus.tsr_x    = 9'(x);
    bus.tsr_xs   = 3'(xs);
    bus.tsr_xf   = xf[0];
    bus.tsr_pal  = 4'(pal);
    bus.tsr_go   = 1'b1;
    @(posedge clk); #1;
    bus.tsr_go   = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!bus.tsr_rdy && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_done"}, 32'(t < 3000), 32'd1);
    check({name, "_drained"}, 32'(exp_w.size() + exp_a.size()), 32'd0);
  endtask
  task automatic abort_flush();
    exp_w.delete();
    exp_a.delete();
  endtask
  // DRAM responder: answers each request after the configured number of wait cycles
  initial begin
    bus.dram_next  = 1'b0;
    bus.dram_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.dram_next) bus.dram_next = 1'b0;
      else if (bus.dram_req) begin
        if (wcnt <= 0) begin
          bus.dram_next  = 1'b1;
          bus.dram_rdata = word(bus.dram_addr);
          wcnt = $urandom_range(whi, wlo);
        end else wcnt--;
      end
    end
  end
  // Monitor: pops expected fetch addresses and line-buffer writes as the DUT presents them
  initial begin
    logic prev_req;
    logic [20:0] prev_addr;
    logic [16:0] e;
    logic [20:0] ea;
    prev_req = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.lb_we) begin
        if (exp_w.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_write: lb_addr %0d lb_data %h, no write expected", bus.lb_addr, bus.lb_data);
        end else begin
          e = exp_w.pop_front();
          check("lb_write", 32'({bus.lb_addr, bus.lb_data}), 32'(e));
        end
        check("write_during_req", 32'(bus.dram_req), 32'd0);
      end
      if (bus.dram_req && !prev_req) begin
        if (exp_a.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_req: dram_addr %h, no fetch expected", bus.dram_addr);
        end else begin
          ea = exp_a.pop_front();
          check("dram_addr", 32'(bus.dram_addr), 32'(ea));
        end
      end else if (bus.dram_req && prev_req) check("dram_addr_stable", 32'(bus.dram_addr), 32'(prev_addr));
      prev_req = bus.dram_req;
      prev_addr = bus.dram_addr;
    end
  end
  initial begin
    int cnt;
    bus.start = 1'b0;
    bus.tsr_go = 1'b0;
    bus.tsr_addr = '0;
    bus.tsr_line = '0;
    bus.tsr_page = '0;
    bus.tsr_x = '0;
    bus.tsr_xs = '0;
    bus.tsr_xf = 1'b0;
    bus.tsr_pal = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(bus.tsr_rdy), 32'd1);
    check("rst_req", 32'(bus.dram_req), 32'd0);
    check("rst_we", 32'(bus.lb_we), 32'd0);
    check("rst_lb_addr", 32'(bus.lb_addr), 32'd0);
    check("rst_lb_data", 32'(bus.lb_data), 32'd0);
    check("rst_dram_addr", 32'(bus.dram_addr), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // unaligned address, zero-wait, duration 1+5N
    use_fix = 1'b1;
    fix[0] = 16'h2143;
    fix[1] = 16'h6587;
    set_wait(0, 0);
    go(8'h01, 9'h1FF, 6'h3F, 0, 0, 0, 5);
    check("go_rdy_low", 32'(bus.tsr_rdy), 32'd0);
    check("go_req_high", 32'(bus.dram_req), 32'd1);
    cnt = 1;
    while (!bus.tsr_rdy && cnt < 500) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("duration_n2", 32'(cnt), 32'd11);
    wait_idle("unaligned");
    go(8'h01, 9'h1FF, 6'h3F, 0, 0, 1, 5);
    wait_idle("xflip");
    // transparency, clipping and X wrap
    fix[0] = 16'h0102;
    fix[1] = 16'h3040;
    go(8'h10, 9'h003, 6'h01, 356, 1, 0, 9);
    wait_idle("clip");
    fix[0] = 16'h1230;
    fix[1] = 16'h0456;
    go(8'h20, 9'h004, 6'h02, 508, 0, 0, 3);
    wait_idle("wrap");
    go(8'h20, 9'h004, 6'h02, 510, 1, 1, 12);
    wait_idle("wrap_flip");
    use_fix = 1'b0;
    // DRAM wait states
    set_wait(7, 7);
    go(8'h33, 9'h055, 6'h11, 40, 1, 0, 6);
    cnt = 0;
    while (bus.dram_req && cnt < 50) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("wait_req_cycles", 32'(cnt), 32'd8);
    wait_idle("wait7");
    // ignored second go
    set_wait(1, 1);
    go(8'h44, 9'h100, 6'h05, 100, 1, 1, 2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.tsr_x = 9'd7;
    bus.tsr_page = 8'hEE;
    bus.tsr_go = 1'b1;
    @(posedge clk); #1;
    bus.tsr_go = 1'b0;
    wait_idle("ignored_go");
    // abort during DRAW of word 2 of 4
    set_wait(0, 0);
    go(8'h05, 9'h0AA, 6'h20, 200, 1, 0, 4);
    repeat (7) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort_draw_rdy", 32'(bus.tsr_rdy), 32'd1);
    abort_flush();
    repeat (3) begin
      @(posedge clk); #1;
    end
    go(8'h06, 9'h0AB, 6'h21, 10, 0, 0, 8);
    wait_idle("after_abort_draw");
    // abort in the same cycle as dram_next
    set_wait(2, 2);
    go(8'h07, 9'h011, 6'h22, 50, 2, 0, 1);
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk); #2;
      if (bus.dram_next) break;
      cnt++;
    end
    check("abort_next_seen", 32'(cnt < 40), 32'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("abort_next_rdy", 32'(bus.tsr_rdy), 32'd1);
    abort_flush();
    repeat (3) begin
      @(posedge clk); #1;
    end
    set_wait(0, 1);
    go(8'h08, 9'h012, 6'h23, 60, 0, 1, 14);
    wait_idle("after_abort_next");
    // asynchronous reset mid-FETCH
    set_wait(30, 30);
    go(8'h09, 9'h013, 6'h24, 70, 1, 0, 7);
    repeat (2) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_req", 32'(bus.dram_req), 32'd0);
    check("arst_we", 32'(bus.lb_we), 32'd0);
    check("arst_rdy", 32'(bus.tsr_rdy), 32'd1);
    check("arst_dram_addr", 32'(bus.dram_addr), 32'd0);
    abort_flush();
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_wait(0, 2);
    go(8'h0A, 9'h014, 6'h25, 80, 1, 1, 11);
    wait_idle("after_reset");
    // randomised tasks
    for (int i = 0; i < 40; i++) begin
      set_wait(0, $urandom_range(3, 0));
      go($urandom_range(255, 0), $urandom_range(511, 0), $urandom_range(63, 0), $urandom_range(511, 0),
         $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(15, 0));
      wait_idle("random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
